// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and helpers for the round key store
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY,
    DRAIN
  } rks_state_t;

  localparam int ROUNDKEY_W = 128;
  localparam int RKS_IDX_W  = 4;

  function automatic int nrk(input int k);
    return k / 32 + 7;
  endfunction

  // Even parity per byte: the stored bit makes each byte-plus-bit have an even count of ones.
  function automatic logic [15:0] byte_parity(input logic [ROUNDKEY_W-1:0] key);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) begin
      p[i] = ^key[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/roundkey_store_if.sv
// rtl/roundkey_store_if.sv - capture/replay handshake bundle between expander, store and round datapath
interface roundkey_store_if;
  import aes_pkg::*;

  logic                  start;
  logic                  wr_valid;
  logic [ROUNDKEY_W-1:0] wr_key;
  logic                  full;
  logic                  rd_start;
  logic                  rd_dir;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ROUNDKEY_W-1:0] rd_key;
  logic [RKS_IDX_W-1:0]  rd_idx;
  logic                  rd_last;
  logic                  err;

  modport master (
    output start, wr_valid, wr_key, rd_start, rd_dir, rd_ready,
    input  full, rd_valid, rd_key, rd_idx, rd_last, err
  );

  modport slave (
    input  start, wr_valid, wr_key, rd_start, rd_dir, rd_ready,
    output full, rd_valid, rd_key, rd_idx, rd_last, err
  );

endinterface

// File: rtl/roundkey_store_ram.sv
// rtl/roundkey_store_ram.sv - roundkey_ram: one-write/one-read synchronous key array with registered read port
module roundkey_ram #(
  parameter int DEPTH = 11,
  parameter int W     = 128,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register doubles as the presented key, so it holds whenever re is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/roundkey_store.sv
// rtl/roundkey_store.sv - captures one key schedule and replays it forward/reverse; ROUNDKEY_STORE_PARITY_EN adds byte parity
module roundkey_store
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic              clk,
  input  logic              reset,
  roundkey_store_if.slave   bus
);

  localparam int                   NRK  = nrk(K);
  localparam logic [RKS_IDX_W-1:0] LAST = RKS_IDX_W'(NRK - 1);

  rks_state_t           state, next_state;
  logic [RKS_IDX_W-1:0] wr_ptr, rd_idx_q, load_idx;
  logic                 full_q, rd_valid_q, rd_last_q, dir_q, err_q;
  logic                 ram_we, ram_re, clear, fill_done, finish, proto_err;
  logic                 load_dir, load_last, par_err;

`ifdef ROUNDKEY_STORE_PARITY_EN
  localparam int RAM_W = ROUNDKEY_W + 16;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;
  assign ram_wdata  = {byte_parity(bus.wr_key), bus.wr_key};
  assign bus.rd_key = ram_rdata[ROUNDKEY_W-1:0];
  assign par_err    = rd_valid_q &&
                      (byte_parity(ram_rdata[ROUNDKEY_W-1:0]) != ram_rdata[RAM_W-1 -: 16]);
`else
  localparam int RAM_W = ROUNDKEY_W;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;
  assign ram_wdata  = bus.wr_key;
  assign bus.rd_key = ram_rdata;
  assign par_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    clear      = 1'b0;
    fill_done  = 1'b0;
    finish     = 1'b0;
    proto_err  = 1'b0;
    load_idx   = rd_idx_q;
    if (bus.start) begin
      next_state = FILL;
      clear      = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        FILL: begin
          if (bus.wr_valid) begin
            ram_we = 1'b1;
            if (wr_ptr == LAST) begin
              fill_done  = 1'b1;
              next_state = READY;
            end
          end
        end
        READY: begin
          proto_err = bus.wr_valid;
          if (bus.rd_start) begin
            next_state = DRAIN;
            ram_re     = 1'b1;
            load_idx   = bus.rd_dir ? LAST : '0;
          end
        end
        DRAIN: begin
          proto_err = bus.rd_start;
          if (rd_valid_q && bus.rd_ready) begin
            if (rd_last_q) begin
              finish     = 1'b1;
              next_state = READY;
            end else begin
              ram_re   = 1'b1;
              load_idx = dir_q ? rd_idx_q - 1'b1 : rd_idx_q + 1'b1;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Direction is latched at rd_start so a pass cannot change course midway.
  assign load_dir  = (state == READY) ? bus.rd_dir : dir_q;
  assign load_last = load_dir ? (load_idx == '0) : (load_idx == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_idx_q   <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_q | proto_err | par_err;
      if (clear) begin
        wr_ptr     <= '0;
        full_q     <= 1'b0;
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end else begin
        if (ram_we) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (fill_done) begin
          full_q <= 1'b1;
        end
        if (ram_re) begin
          rd_valid_q <= 1'b1;
          rd_idx_q   <= load_idx;
          rd_last_q  <= load_last;
          dir_q      <= load_dir;
        end
        if (finish) begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
        end
      end
    end
  end

  roundkey_ram #(
    .DEPTH (NRK),
    .W     (RAM_W),
    .AW    (RKS_IDX_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (load_idx),
    .rdata (ram_rdata)
  );

  assign bus.full     = full_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_idx   = rd_idx_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.err      = err_q | par_err;

endmodule

// File: tb/tb_roundkey_store.sv
// tb/tb_roundkey_store.sv - randomized check of roundkey_store (K=128 and K=256) against an AES key-schedule model
module tb_roundkey_store;

  logic         clk = 1'b0;
  logic         reset, sel;
  logic         start, wr_valid, rd_start, rd_dir, rd_ready;
  logic [127:0] wr_key;

  always #5 clk = ~clk;

  roundkey_store_if b0();
  roundkey_store_if b1();

  assign b0.start    = start & ~sel;
  assign b0.wr_valid = wr_valid & ~sel;
  assign b0.rd_start = rd_start & ~sel;
  assign b0.wr_key   = wr_key;
  assign b0.rd_dir   = rd_dir;
  assign b0.rd_ready = rd_ready;
  assign b1.start    = start & sel;
  assign b1.wr_valid = wr_valid & sel;
  assign b1.rd_start = rd_start & sel;
  assign b1.wr_key   = wr_key;
  assign b1.rd_dir   = rd_dir;
  assign b1.rd_ready = rd_ready;

  roundkey_store #(.K(128)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  roundkey_store #(.K(256)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  logic         o_full, o_valid, o_last, o_err;
  logic [127:0] o_key;
  logic [3:0]   o_idx;
  assign o_full  = sel ? b1.full     : b0.full;
  assign o_valid = sel ? b1.rd_valid : b0.rd_valid;
  assign o_last  = sel ? b1.rd_last  : b0.rd_last;
  assign o_err   = sel ? b1.err      : b0.err;
  assign o_key   = sel ? b1.rd_key   : b0.rd_key;
  assign o_idx   = sel ? b1.rd_idx   : b0.rd_idx;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] ref_keys [16];
  bit           ref_err;
  logic [7:0]   sbox [256];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand128(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic int nrk_m();
    return sel ? 15 : 11;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; wr_valid = 1'b0; rd_start = 1'b0;
    rd_dir = 1'b0; rd_ready = 1'b1; wr_key = '0;
    repeat (2) tick();
    reset = 1'b1;
    ref_err = 1'b0;
    tick();
    check_eq("rst_full", o_full, 0);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_last", o_last, 0);
    check_eq("rst_err", o_err, 0);
    check_eq("rst_key", o_key, 0);
    check_eq("rst_idx", o_idx, 0);
  endtask

  // A junk wr_valid rides along with start; it must not land in entry 0.
  task automatic fill(input int n_writes, input bit gapped, input bit from_aes, input logic [127:0] aes_key);
    start = 1'b1; wr_valid = 1'b1; wr_key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0; wr_valid = 1'b0;
    check_eq("full_start", o_full, 0);
    if (from_aes) expand128(aes_key);
    else for (int i = 0; i < nrk_m(); i++) ref_keys[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < n_writes; i++) begin
      if (gapped) tick();
      wr_valid = 1'b1; wr_key = ref_keys[i];
      tick();
      wr_valid = 1'b0;
      check_eq("full_fill", o_full, (i + 1 == nrk_m()));
    end
  endtask

  task automatic replay(input bit dir, input int stall_idx, input int stall_n, input bit rnd, input int poke_at);
    rd_dir = dir; rd_ready = 1'b1; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int n = 0; n < nrk_m(); n++) begin
      int e;
      int st;
      e  = dir ? nrk_m() - 1 - n : n;
      st = (e == stall_idx) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      check_eq("rd_valid", o_valid, 1);
      check_eq("rd_idx", o_idx, e);
      check_eq("rd_key", o_key, ref_keys[e]);
      check_eq("rd_last", o_last, (n == nrk_m() - 1));
      if (st > 0) rd_ready = 1'b0;
      for (int s = 0; s < st; s++) begin
        tick();
        check_eq("hold_key", o_key, ref_keys[e]);
        check_eq("hold_idx", o_idx, e);
        check_eq("hold_valid", o_valid, 1);
      end
      rd_ready = 1'b1;
      if (n == poke_at) begin
        rd_start = 1'b1;
        ref_err  = 1'b1;
      end
      tick();
      rd_start = 1'b0;
    end
    check_eq("end_valid", o_valid, 0);
    check_eq("end_last", o_last, 0);
    check_eq("end_full", o_full, 1);
    check_eq("end_err", o_err, ref_err);
  endtask

  task automatic stray_write();
    wr_valid = 1'b1; wr_key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    wr_valid = 1'b0;
    ref_err = 1'b1;
    check_eq("stray_wr_err", o_err, 1);
    check_eq("stray_wr_full", o_full, 1);
  endtask

  initial begin
    sel = 1'b0;
    build_sbox();
    do_reset();

    // IDLE ignores reads and writes without flagging an error.
    rd_start = 1'b1; wr_valid = 1'b1;
    tick();
    rd_start = 1'b0; wr_valid = 1'b0;
    check_eq("idle_valid", o_valid, 0);
    check_eq("idle_err", o_err, 0);

    fill(11, 1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    check_eq("model_rk0", ref_keys[0], 128'h000102030405060708090a0b0c0d0e0f);
    check_eq("model_rk10", ref_keys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    replay(1'b0, 4, 3, 1'b0, -1);
    replay(1'b1, -1, 0, 1'b0, -1);
    replay(1'b0, -1, 0, 1'b1, -1);
    replay(1'b0, -1, 0, 1'b1, 2);

    // Abort mid-fill; err survives start.
    fill(6, 1'b0, 1'b0, '0);
    check_eq("abort_full", o_full, 0);
    fill(11, 1'b0, 1'b0, '0);
    replay(1'b0, -1, 0, 1'b1, -1);

    do_reset();
    fill(11, 1'b0, 1'b0, '0);
    stray_write();
    replay(1'b1, -1, 0, 1'b1, -1);
    replay(1'b0, -1, 0, 1'b1, -1);

    sel = 1'b1;
    do_reset();
    fill(15, 1'b1, 1'b0, '0);
    replay(1'b0, -1, 0, 1'b1, -1);
    replay(1'b1, 7, 2, 1'b0, -1);

    // Asynchronous reset landing between clock edges during a pass.
    sel = 1'b0;
    do_reset();
    fill(11, 1'b0, 1'b0, '0);
    stray_write();
    rd_dir = 1'b0; rd_ready = 1'b1; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    check_eq("pre_arst_valid", o_valid, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_valid", o_valid, 0);
    check_eq("arst_full", o_full, 0);
    check_eq("arst_err", o_err, 0);
    check_eq("arst_key", o_key, 0);
    tick();
    reset = 1'b1;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check_eq("post_arst_valid", o_valid, 0);
    check_eq("post_arst_full", o_full, 0);
    check_eq("post_arst_err", o_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/roundkey_store.md
Name: roundkey_store

Overview:
- Buffers every round key produced by the key-expansion stage during one forward expansion pass. Sits directly downstream of the expander.
- Replays the stored keys to the cipher round datapath, in forward order for encryption or reverse order for decryption.
- Once full, serves any number of replays without re-running expansion.

Parameters:
- K, 128, key length in bits; legal values 128/192/256.
- NRK, K/32+7 (derived, localparam), number of round keys: 11/13/15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; clears store, begins capture of a new key schedule
- wr_valid  in  1  expander output valid this cycle
- wr_key  in  128  round key from expander
- full  out  1  all NRK keys captured
- rd_start  in  1  pulse; begin a replay pass
- rd_dir  in  1  0 = round 0 first (encrypt), 1 = round NRK-1 first (decrypt); sampled with rd_start
- rd_valid  out  1  rd_key holds a valid key
- rd_ready  in  1  consumer accepts rd_key
- rd_key  out  128  current round key
- rd_idx  out  4  round number of rd_key
- rd_last  out  1  rd_key is final key of pass
- err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, async):
  - state IDLE.
  - full, rd_valid, rd_last, err = 0; rd_key = 0; rd_idx = 0; write pointer = 0.
  - Storage contents need no reset.
- States: IDLE, FILL, READY, DRAIN.
- IDLE:
  - start → FILL.
  - wr_valid and rd_start are ignored.
- FILL:
  - Each cycle with wr_valid=1, write wr_key at wr_ptr and increment wr_ptr.
  - The write that makes wr_ptr reach NRK moves the block to READY; full=1 on the next cycle.
  - Keys arrive one per cycle; gaps in wr_valid are allowed.
- READY:
  - full=1.
  - wr_valid=1 sets err; storage is unchanged.
  - rd_start → DRAIN, loading the first key: index 0 if rd_dir=0, index NRK-1 if rd_dir=1.
- DRAIN:
  - rd_valid=1 starting the cycle after rd_start (1-cycle latency); rd_key/rd_idx are registered.
  - A transfer occurs when rd_valid & rd_ready. Then the next key loads the following cycle: idx+1 (forward) or idx-1 (reverse), giving back-to-back throughput of one key per cycle.
  - rd_key, rd_idx and rd_last hold stable while rd_valid=1 and rd_ready=0.
  - rd_last=1 when idx = NRK-1 (forward) or idx = 0 (reverse).
  - Transfer with rd_last=1 → READY; rd_valid and rd_last drop next cycle.
  - rd_start during DRAIN is ignored and sets err.
- start in any state:
  - Go to FILL, wr_ptr=0, full=0, rd_valid=0, rd_last=0.
  - wr_valid in the same cycle as start is NOT captured.
  - err is not cleared by start; only reset clears it.
- rd_start while state ≠ READY/DRAIN: ignored, no err.
- rd_idx width: 4 bits, which covers up to 15 keys.

Optional Feature:
- Macro ROUNDKEY_STORE_PARITY_EN.
- Defined:
  - Store one even-parity bit per byte (16 bits per entry) on write.
  - Recheck parity on every read load. Any mismatch sets err (sticky) in the cycle the key is presented on rd_key.
  - The data path is unchanged.
- Undefined: no parity storage or logic; err reflects protocol errors only.

Decomposition:
- Shared package aes_pkg:
  - state enum type (IDLE, FILL, READY, DRAIN).
  - function nrk(K) returning K/32+7.
  - constant ROUNDKEY_W = 128.
- One sub-module roundkey_ram: NRK×128 (+16 parity when enabled) storage array, synchronous write, synchronous read, single write port and single read port. The block contains no other sub-modules.

Test Plan:
- AES-128 forward capture and encrypt replay:
  - Stimulus: reset, start, then 11 back-to-back wr_valid keys from key 000102030405060708090a0b0c0d0e0f, then rd_start with rd_dir=0 and rd_ready=1.
  - Response: full rises after the 11th write. Keys stream on consecutive cycles, first rd_key=000102030405060708090a0b0c0d0e0f with rd_idx=0, last rd_key=13111d7fe3944a17f307a78b4d2b30c5 with rd_idx=10 and rd_last=1.
- Decrypt replay on the same store:
  - Stimulus: rd_start with rd_dir=1.
  - Response: first rd_key=13111d7fe3944a17f307a78b4d2b30c5 with rd_idx=10; final rd_key=000102...0f with rd_idx=0 and rd_last=1; state returns to READY and full stays 1.
- Backpressure:
  - Stimulus: during a pass, hold rd_ready=0 for 3 cycles at rd_idx=4.
  - Response: rd_key and rd_idx stay stable for those 3 cycles; no key is skipped or duplicated.
- K=256 with gapped writes:
  - Stimulus: 15 writes with wr_valid toggling every other cycle.
  - Response: full is set only after the 15th write; replay yields 15 keys with rd_idx running 0..14.
- Abort and errors:
  - Stimulus: start at write 6 of 11, then refill with a new key. Separately, wr_valid in READY, and rd_start during DRAIN.
  - Response: after the abort, rd_idx=0 shows the new key 0 and full=0 until 11 new writes complete. The stray wr_valid and rd_start set err=1, and err holds until reset.
- Async reset mid-DRAIN:
  - Stimulus: assert reset low between clock edges during a pass.
  - Response: rd_valid, full and err go to 0 immediately; the block is in IDLE after release.
